ship_placer: RTL
================

# ship_placer

Game-setup controller that sits directly upstream of the dynamic screen renderer. It clears the player's 10×10 board RAM, moves a placement cursor in response to debounced button pulses, and validates each of the five ships against board bounds and existing ships. Accepted ships are written into the board RAM. It produces the `cursor` and `ghost_ship` signals that the renderer consumes.

## Interface
Parameters:
- `GRID`, 10, board edge length in tiles; legal range 2..16.

Ports:
- `clk`  in  1  system/pixel clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse; starts setup.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  single-cycle move pulses, already debounced.
- `btn_rot`  in  1  pulse; toggles orientation (0 = horizontal, 1 = vertical).
- `btn_place`  in  1  pulse; tries to place the current ship.
- `query_col`, `query_row`  in  4 each  tile currently being drawn by the renderer.
- `ram_rdata`  in  2  board RAM read data; valid 1 cycle after `ram_addr`.
- `ram_addr`  out  8  board RAM address `{row[3:0], col[3:0]}`.
- `ram_we`  out  1  board RAM write enable.
- `ram_wdata`  out  2  tile code: EMPTY=0, HIT=1, MISS=2, SHIP=3.
- `cursor`  out  8  `{col[3:0], row[3:0]}`; origin of the current ship.
- `ghost_ship`  out  1  the query tile lies inside the current ship's footprint.
- `ship_idx`  out  3  ship being placed, 0..4.
- `place_err`  out  1  1-cycle pulse on a rejected placement.
- `setup_done`  out  1  level; all five ships are placed.

## Operation
- Ship lengths by `ship_idx`: 0→5, 1→4, 2→3, 3→3, 4→2.
- Footprint: horizontal covers cols col..col+len-1 on the cursor row; vertical covers rows row..row+len-1 on the cursor column.
- States and transitions:
  - IDLE → CLEAR on `start`.
  - CLEAR: write EMPTY to every tile, row-major, one tile per cycle, GRID² cycles. Then set `ship_idx`=0, cursor=0, orient=0, and go to MOVE.
  - MOVE: on `btn_place` → CHECK; otherwise handle move and rotate pulses.
  - CHECK: read each footprint tile. If any read returns SHIP → pulse `place_err` and return to MOVE. If none do → WRITE.
  - WRITE: write SHIP to each footprint tile, one per cycle. If `ship_idx`=4 → DONE; otherwise increment `ship_idx`, set orient=0, keep the cursor clamped, and return to MOVE.
  - DONE: `setup_done`=1. `start` → CLEAR.
- Priority when several pulses arrive in the same cycle: place > rot > up > down > left > right. Only the winning pulse acts.
- Moves:
  - Moves saturate; there is no wrap-around.
  - The cursor is clamped so the footprint stays on the board. Max origin on the long axis is GRID-len; on the short axis it is GRID-1.
  - A rotation that would overflow pulls the origin back to GRID-len on the new long axis.
- Button pulses outside MOVE, and `start` outside IDLE/DONE, are ignored.
- Reset does not clear the RAM; clearing happens only in CLEAR.
- Outside MOVE, `ram_we`=0 except in CLEAR and WRITE.

## Timing
- Reset values: `cursor`=8'h00, `ship_idx`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `ghost_ship`=0, `place_err`=0, `setup_done`=0. The state is IDLE.
- A move or rotate pulse in cycle n shows on `cursor` in cycle n+1.
- CHECK: addresses are issued on cycles 0..len-1 and data is sampled on cycles 1..len. The verdict comes len+1 cycles after entry, and `place_err` asserts in that cycle.
- WRITE takes exactly len cycles. `ram_we` is high on each of them.
- Place-to-MOVE latency on success: 2·len+1 cycles.
- `ghost_ship` is registered. It reflects the `query_*` values from the previous cycle, and the renderer compensates by one cycle.
- If reset is asserted mid-CHECK/WRITE, all state returns to reset values immediately. A partly written ship may stay in RAM until the next CLEAR.

## Configuration
- `GHOST_SHIP_EN` defined:
  - `ghost_ship`=1 when the FSM is in MOVE and the query tile is inside the footprint.
  - Otherwise `ghost_ship`=0.
- `GHOST_SHIP_EN` undefined:
  - `ghost_ship` is tied to 0.
  - The `query_*` inputs are unused.
  - The footprint compare logic is not built.

## Test plan
- `start` after reset → 100 writes of 0 covering addresses 0x00..0x99 row-major, then MOVE with `cursor`=8'h00 and `ship_idx`=0.
- Ship 0 horizontal, 9 `btn_right` pulses → cursor col saturates at 5 (`cursor`=8'h50).
- Then `btn_rot` → orientation becomes vertical, col stays 5, row is clamped to 0..5 in later moves.
- Ship 0 placed horizontally at 8'h00 → `ram_we` high 5 cycles at addresses 0x00..0x04 with data 3. `ship_idx` becomes 1.
- Ship 1 vertical at 8'h20 (overlaps 0x02) → no writes, `place_err` pulses exactly once 5 cycles after `btn_place`, state returns to MOVE.
- Five valid placements → `setup_done`=1. Button pulses afterwards change nothing.
- `btn_up` and `btn_left` in the same cycle at row 3, col 3 → only the row decrements.
- Reset asserted during WRITE → outputs take reset values asynchronously.
- With `GHOST_SHIP_EN` and a vertical length-4 ship at 8'h12 → `ghost_ship`=1 exactly for query (1,2)..(1,5), one cycle after each query.

Source files
------------

// File: rtl/ship_placer.sv
// Game-setup controller: clears the board RAM, steers the placement cursor and validates and writes five ships.
// Define GHOST_SHIP_EN to build the registered ghost_ship footprint compare; otherwise ghost_ship is tied low.
module ship_placer #(
  parameter int GRID = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rot,
  input  logic       btn_place,
  input  logic [3:0] query_col,
  input  logic [3:0] query_row,
  input  logic [1:0] ram_rdata,
  output logic [7:0] ram_addr,
  output logic       ram_we,
  output logic [1:0] ram_wdata,
  output logic [7:0] cursor,
  output logic       ghost_ship,
  output logic [2:0] ship_idx,
  output logic       place_err,
  output logic       setup_done
);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_MOVE, S_CHECK, S_WRITE, S_DONE} state_t;

  localparam logic [1:0] T_EMPTY = 2'd0;
  localparam logic [1:0] T_SHIP  = 2'd3;
  localparam logic [4:0] G       = 5'(GRID);
  localparam logic [3:0] G_MAX   = 4'(GRID - 1);

  function automatic logic [2:0] ship_len(input logic [2:0] idx);
    case (idx)
      3'd0:       ship_len = 3'd5;
      3'd1:       ship_len = 3'd4;
      3'd2, 3'd3: ship_len = 3'd3;
      default:    ship_len = 3'd2;
    endcase
  endfunction

  // Largest legal origin on the long axis; zero when the ship cannot fit.
  function automatic logic [3:0] long_max(input logic [2:0] idx);
    logic [4:0] l;
    l = {2'b00, ship_len(idx)};
    long_max = (G > l) ? 4'(G - l) : 4'd0;
  endfunction

  function automatic logic [3:0] min4(input logic [3:0] a, input logic [3:0] b);
    min4 = (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] tile_addr(input logic [3:0] col, input logic [3:0] row,
                                           input logic vert, input logic [2:0] k);
    logic [3:0] c;
    logic [3:0] r;
    c = vert ? col : col + {1'b0, k};
    r = vert ? row + {1'b0, k} : row;
    tile_addr = {r, c};
  endfunction

  state_t     state_q, state_d;
  logic [3:0] col_q, col_d, row_q, row_d;
  logic       orient_q, orient_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] cnt_q, cnt_d;
  logic       hit_q, hit_d;
  logic [7:0] addr_q, addr_d;
  logic       we_q, we_d;
  logic [1:0] wdata_q, wdata_d;
  logic       err_q, err_d;
  logic       ghost_q, ghost_d;
  logic [2:0] cur_len;
  logic [3:0] lmax, row_lim, col_lim;

  assign cur_len = ship_len(idx_q);
  assign lmax    = long_max(idx_q);
  assign row_lim = orient_q ? lmax : G_MAX;
  assign col_lim = orient_q ? G_MAX : lmax;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    orient_d = orient_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CLEAR;
          addr_d  = 8'h00;
          we_d    = 1'b1;
          wdata_d = T_EMPTY;
        end
      end
      S_CLEAR: begin
        if (addr_q[3:0] != G_MAX) begin
          addr_d = addr_q + 8'd1;
          we_d   = 1'b1;
        end else if (addr_q[7:4] != G_MAX) begin
          addr_d = {addr_q[7:4] + 4'd1, 4'd0};
          we_d   = 1'b1;
        end else begin
          state_d  = S_MOVE;
          idx_d    = 3'd0;
          col_d    = 4'd0;
          row_d    = 4'd0;
          orient_d = 1'b0;
          cnt_d    = 3'd0;
        end
      end
      S_MOVE: begin
        if (btn_place) begin
          state_d = S_CHECK;
          cnt_d   = 3'd1;
          hit_d   = 1'b0;
          addr_d  = tile_addr(col_q, row_q, orient_q, 3'd1);
        end else if (btn_rot) begin
          orient_d = ~orient_q;
          if (!orient_q) row_d = min4(row_q, lmax);
          else           col_d = min4(col_q, lmax);
        end else if (btn_up) begin
          if (row_q != 4'd0) row_d = row_q - 4'd1;
        end else if (btn_down) begin
          if (row_q < row_lim) row_d = row_q + 4'd1;
        end else if (btn_left) begin
          if (col_q != 4'd0) col_d = col_q - 4'd1;
        end else if (btn_right) begin
          if (col_q < col_lim) col_d = col_q + 4'd1;
        end
      end
      S_CHECK: begin
        // rdata now holds footprint tile cnt_q-1, addressed one cycle earlier.
        hit_d = hit_q | (ram_rdata == T_SHIP);
        if (cnt_q == cur_len) begin
          cnt_d = 3'd0;
          if (hit_d) begin
            state_d = S_MOVE;
            err_d   = 1'b1;
          end else begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            wdata_d = T_SHIP;
            addr_d  = tile_addr(col_q, row_q, orient_q, 3'd0);
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q + 3'd1 < cur_len) addr_d = tile_addr(col_q, row_q, orient_q, cnt_q + 3'd1);
        end
      end
      S_WRITE: begin
        if (cnt_q == 3'(cur_len - 3'd1)) begin
          cnt_d   = 3'd0;
          wdata_d = T_EMPTY;
          if (idx_q == 3'd4) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_MOVE;
            idx_d    = idx_q + 3'd1;
            orient_d = 1'b0;
            col_d    = min4(col_q, long_max(idx_q + 3'd1));
          end
        end else begin
          cnt_d  = cnt_q + 3'd1;
          we_d   = 1'b1;
          addr_d = tile_addr(col_q, row_q, orient_q, cnt_q + 3'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // In MOVE the address tracks the origin so CHECK sees tile 0 on its first cycle.
    if (state_d == S_MOVE) addr_d = {row_d, col_d};
  end

`ifdef GHOST_SHIP_EN
  logic inside_fp;
  always_comb begin
    inside_fp = 1'b0;
    if (orient_q)
      inside_fp = (query_col == col_q) && (query_row >= row_q) &&
                  ({1'b0, query_row} < {1'b0, row_q} + {2'b00, cur_len});
    else
      inside_fp = (query_row == row_q) && (query_col >= col_q) &&
                  ({1'b0, query_col} < {1'b0, col_q} + {2'b00, cur_len});
    ghost_d = (state_q == S_MOVE) && inside_fp;
  end
`else
  wire unused_query = ^{query_col, query_row};
  assign ghost_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      col_q    <= 4'd0;
      row_q    <= 4'd0;
      orient_q <= 1'b0;
      idx_q    <= 3'd0;
      cnt_q    <= 3'd0;
      hit_q    <= 1'b0;
      addr_q   <= 8'h00;
      we_q     <= 1'b0;
      wdata_q  <= 2'd0;
      err_q    <= 1'b0;
      ghost_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      orient_q <= orient_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      ghost_q  <= ghost_d;
    end
  end

  assign ram_addr   = addr_q;
  assign ram_we     = we_q;
  assign ram_wdata  = wdata_q;
  assign cursor     = {col_q, row_q};
  assign ghost_ship = ghost_q;
  assign ship_idx   = idx_q;
  assign place_err  = err_q;
  assign setup_done = (state_q == S_DONE);
endmodule
